// File: rtl/booth_mult_scheduler_pkg.sv
// Shared widths, scheduler state encoding and operand bundle for the Booth
// multiplier scheduler slice.
package booth_sched_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operands_t;

endpackage

// File: rtl/booth_mult_scheduler_if.sv
// Request/response bundle between the datapath clients (master) and the
// multiplier scheduler (slave).
interface booth_mult_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    import booth_sched_pkg::*;

    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ*OP_W-1:0] req_a_i;
    logic [NUM_REQ*OP_W-1:0] req_b_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic                    resp_valid_o;
    logic                    resp_ready_i;
    logic [ID_W-1:0]         resp_id_o;
    logic [PROD_W-1:0]       resp_product_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_id_o, resp_product_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_id_o, resp_product_o
    );

endinterface

// File: rtl/booth_mult_scheduler_core.sv
// Radix-2 Booth 8x8 signed multiplier: one enable pulse starts it, 16 step
// cycles (add/sub then shift per bit), then it parks in FINISH until enabled again.
module booth_mult_core
    import booth_sched_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     en_i,
    input  logic signed [OP_W-1:0]   mcand_i,
    input  logic signed [OP_W-1:0]   mplier_i,
    output logic                     dv_o,
    output logic signed [PROD_W-1:0] product_o
);

    localparam logic [1:0] C_START  = 2'd0;
    localparam logic [1:0] C_RUN    = 2'd1;
    localparam logic [1:0] C_FINISH = 2'd2;

    logic [1:0]             cst_q, cst_d;
    logic [3:0]             cnt_q, cnt_d;
    logic signed [OP_W:0]   acc_q, acc_d;
    logic [OP_W-1:0]        q_q, q_d;
    logic                   qm1_q, qm1_d;
    logic signed [OP_W:0]   mcand_x;

    // One guard bit on the accumulator so subtracting -128 stays representable.
    assign mcand_x = {mcand_i[OP_W-1], mcand_i};

    always_comb begin
        cst_d = cst_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        case (cst_q)
            C_START: begin
                if (en_i) begin
                    cst_d = C_RUN;
                    cnt_d = '0;
                    acc_d = '0;
                    q_d   = mplier_i;
                    qm1_d = 1'b0;
                end
            end
            C_RUN: begin
                if (!cnt_q[0]) begin
                    case ({q_q[0], qm1_q})
                        2'b01:   acc_d = acc_q + mcand_x;
                        2'b10:   acc_d = acc_q - mcand_x;
                        default: acc_d = acc_q;
                    endcase
                end else begin
                    {acc_d, q_d, qm1_d} = {acc_q[OP_W], acc_q, q_q};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) cst_d = C_FINISH;
            end
            C_FINISH: begin
                if (en_i) cst_d = C_START;
            end
            default: cst_d = C_START;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cst_q <= C_START;
            cnt_q <= '0;
            acc_q <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
        end else begin
            cst_q <= cst_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
        end
    end

    assign dv_o      = (cst_q == C_FINISH);
    assign product_o = {acc_q[OP_W-1:0], q_q};

endmodule

// File: rtl/booth_mult_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first pending request at or after ptr_i,
// searching upward with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one Booth multiplier core among NUM_REQ
// requesters; one multiply in flight, result returned over valid/ready.
module booth_mult_scheduler
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    booth_mult_scheduler_if.slave  bus,
    output logic                   busy_o
);

    logic [2:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    operands_t          ops_q, ops_d;
    logic [PROD_W-1:0]  prod_q, prod_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;

    logic                     core_en;
    logic                     core_dv;
    logic signed [PROD_W-1:0] core_prod;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (bus.req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Operands come straight from the registers: the core re-reads the
    // multiplicand every add step, so they must not move until RELEASE.
    booth_mult_core u_core (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .en_i      (core_en),
        .mcand_i   ($signed(ops_q.a)),
        .mplier_i  ($signed(ops_q.b)),
        .dv_o      (core_dv),
        .product_o (core_prod)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        ops_d    = ops_q;
        prod_d   = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    id_d     = grant_idx;
                    ops_d.a  = bus.req_a_i[grant_idx*OP_W +: OP_W];
                    ops_d.b  = bus.req_b_i[grant_idx*OP_W +: OP_W];
                    rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_dv) begin
                    prod_d  = core_prod;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready_i) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            ops_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            ops_q    <= ops_d;
            prod_q   <= prod_d;
        end
    end

    // The accept pulse is also masked by reset since IDLE is entered asynchronously.
    assign bus.req_ready_o    = (state_q == ST_IDLE && reset_ni) ? grant : '0;
    assign bus.resp_valid_o   = (state_q == ST_RESP);
    assign bus.resp_id_o      = id_q;
    assign bus.resp_product_o = prod_q;
    assign core_en            = (state_q == ST_LAUNCH) || (state_q == ST_RELEASE);
    assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Bench for booth_mult_scheduler: directed corner cases plus random traffic,
// all checked against a cycle-level reference of arbitration, latency and product.
module tb_booth_mult_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    logic busy_o;

    booth_mult_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

    booth_mult_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 16'(sa * sb);
    endfunction

    // Reference model state: one transaction at a time, timed from its accept cycle.
    int          m_ptr = 0;
    bit          infl = 1'b0;
    int          acc_cyc = 0;
    int          eid = 0;
    logic [7:0]  ea, eb;
    logic [15:0] ep;
    bit          prev_en = 1'b0;
    int          g_id[$];
    int          g_cyc[$];

    always @(negedge clk_i) begin : mon
        int k;
        int g;
        #2;
        if (!reset_ni) begin
            m_ptr   = 0;
            infl    = 1'b0;
            prev_en = 1'b0;
        end else begin
            chk("en_pair", {31'b0, prev_en & dut.core_en}, 0);
            if (infl) begin
                k = cyc - acc_cyc;
                chk("rdy_busy", {28'b0, bus.req_ready_o}, 0);
                chk("en_sched", {31'b0, dut.core_en}, {31'b0, (k == 1 || k == 19)});
                if (k <= 19) begin
                    chk("op_a", {24'b0, dut.ops_q.a}, {24'b0, ea});
                    chk("op_b", {24'b0, dut.ops_q.b}, {24'b0, eb});
                end
                chk("resp_valid", {31'b0, bus.resp_valid_o}, {31'b0, k >= 20});
                if (k >= 20) begin
                    chk("resp_id", {30'b0, bus.resp_id_o}, eid);
                    chk("resp_prod", {16'b0, bus.resp_product_o}, {16'b0, ep});
                    if (bus.resp_ready_i) infl = 1'b0;
                end
            end else begin
                g = rr_pick(bus.req_valid_i, m_ptr);
                chk("grant", {28'b0, bus.req_ready_o}, (g >= 0) ? (32'd1 << g) : 32'd0);
                chk("en_idle", {31'b0, dut.core_en}, 0);
                chk("rv_idle", {31'b0, bus.resp_valid_o}, 0);
                if (g >= 0) begin
                    infl    = 1'b1;
                    acc_cyc = cyc;
                    eid     = g;
                    ea      = bus.req_a_i[g*8 +: 8];
                    eb      = bus.req_b_i[g*8 +: 8];
                    ep      = ref_prod(ea, eb);
                    m_ptr   = (g + 1) % NUM_REQ;
                    g_id.push_back(g);
                    g_cyc.push_back(cyc);
                end
            end
            prev_en = dut.core_en;
        end
    end

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        bus.req_a_i[id*8 +: 8] = a;
        bus.req_b_i[id*8 +: 8] = b;
    endtask

    task automatic wait_infl(input string tag);
        int t = 0;
        #3;
        while (!infl && t < 50) begin
            @(negedge clk_i); #3; t++;
        end
        chk({tag, "_accept"}, {31'b0, infl}, 1);
    endtask

    task automatic wait_resp(input string tag);
        int t = 0;
        #3;
        while (!bus.resp_valid_o && t < 60) begin
            @(negedge clk_i); #3; t++;
        end
        chk({tag, "_rv"}, {31'b0, bus.resp_valid_o}, 1);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        @(negedge clk_i);
        bus.req_valid_i  = '0;
        bus.resp_ready_i = 1'b1;
        #3;
        while ((busy_o || infl) && t < 100) begin
            @(negedge clk_i); #3; t++;
        end
        chk({tag, "_idle"}, {31'b0, busy_o}, 0);
        bus.resp_ready_i = 1'b0;
    endtask

    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input string tag);
        int acc;
        @(negedge clk_i);
        set_ops(id, a, b);
        bus.req_valid_i  = 4'(1 << id);
        bus.resp_ready_i = 1'b0;
        wait_infl(tag);
        if (!infl) return;
        acc = acc_cyc;
        @(negedge clk_i);
        bus.req_valid_i = '0;
        wait_resp(tag);
        chk({tag, "_lat"}, cyc - acc, 20);
        chk({tag, "_id"}, {30'b0, bus.resp_id_o}, id);
        chk({tag, "_prod"}, {16'b0, bus.resp_product_o}, {16'b0, exp_p});
        @(negedge clk_i);
        bus.resp_ready_i = 1'b1;
        @(negedge clk_i);
        bus.resp_ready_i = 1'b0;
        #3;
        chk({tag, "_done"}, {31'b0, busy_o}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, {28'b0, bus.req_ready_o}, 0);
        chk({tag, "_rv"}, {31'b0, bus.resp_valid_o}, 0);
        chk({tag, "_id"}, {30'b0, bus.resp_id_o}, 0);
        chk({tag, "_prod"}, {16'b0, bus.resp_product_o}, 0);
        chk({tag, "_busy"}, {31'b0, busy_o}, 0);
        chk({tag, "_ptr"}, {30'b0, dut.rr_ptr_q}, 0);
        chk({tag, "_opa"}, {24'b0, dut.ops_q.a}, 0);
        chk({tag, "_opb"}, {24'b0, dut.ops_q.b}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_ni         = 1'b0;
        bus.req_valid_i  = '0;
        bus.resp_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    logic [7:0]  c_a [4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
    logic [7:0]  c_b [4] = '{8'h80, 8'h01, 8'h80, 8'hFF};
    logic [15:0] c_p [4] = '{16'h4000, 16'hFF80, 16'hC080, 16'h0000};

    initial begin : main
        int base, hs, acc, t;
        logic [7:0] ba, bb;
        bus.req_valid_i  = 4'hF;
        bus.req_a_i      = '0;
        bus.req_b_i      = '0;
        bus.resp_ready_i = 1'b0;
        reset_ni         = 1'b0;

        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("por");
        bus.req_valid_i = '0;
        reset_ni = 1'b1;

        run_op(0, 8'd3, 8'hFB, 16'hFFF1, "single");

        for (int i = 0; i < 4; i++)
            run_op((i + 1) % NUM_REQ, c_a[i], c_b[i], c_p[i], $sformatf("corner%0d", i));

        // Fairness: everyone requests continuously from a fresh pointer.
        do_reset();
        @(negedge clk_i);
        bus.req_a_i      = $urandom;
        bus.req_b_i      = $urandom;
        bus.resp_ready_i = 1'b1;
        bus.req_valid_i  = 4'hF;
        base = g_id.size();
        t = 0;
        #3;
        while (g_id.size() < base + 6 && t < 200) begin
            @(negedge clk_i); #3; t++;
        end
        @(negedge clk_i);
        bus.req_valid_i = '0;
        chk("fair_count", g_id.size() - base, 6);
        if (g_id.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("fair_id%0d", i), g_id[base + i], i % 4);
                if (i > 0) chk($sformatf("fair_gap%0d", i), g_cyc[base + i] - g_cyc[base + i - 1], 21);
            end
        end
        wait_idle("fair");

        // Backpressure: others pending while the result is held.
        ba = 8'($urandom);
        bb = 8'($urandom);
        @(negedge clk_i);
        set_ops(1, ba, bb);
        bus.req_valid_i  = 4'b0010;
        bus.resp_ready_i = 1'b0;
        wait_infl("bp");
        @(negedge clk_i);
        bus.req_valid_i = 4'hF;
        wait_resp("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i); #3;
            chk("bp_rdy", {28'b0, bus.req_ready_o}, 0);
            chk("bp_prod", {16'b0, bus.resp_product_o}, {16'b0, ref_prod(ba, bb)});
            chk("bp_id", {30'b0, bus.resp_id_o}, 1);
        end
        @(negedge clk_i);
        bus.resp_ready_i = 1'b1;
        hs   = cyc;
        base = g_id.size();
        @(negedge clk_i);
        bus.resp_ready_i = 1'b0;
        #3;
        chk("bp_resume_n", g_id.size() - base, 1);
        if (g_id.size() > base) chk("bp_resume_cyc", g_cyc[base] - hs, 1);
        wait_idle("bp");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            bus.req_valid_i  = 4'($urandom_range(0, 15));
            bus.req_a_i      = $urandom;
            bus.req_b_i      = $urandom;
            if ($urandom_range(0, 7) == 0) bus.req_a_i[8*$urandom_range(0, 3) +: 8] = 8'h80;
            bus.resp_ready_i = ($urandom_range(0, 3) != 0);
        end
        wait_idle("rand");

        // Reset in the middle of a multiply.
        @(negedge clk_i);
        set_ops(0, 8'd5, 8'd9);
        bus.req_valid_i = 4'b0001;
        wait_infl("rst");
        acc = acc_cyc;
        @(negedge clk_i);
        bus.req_valid_i = '0;
        while (cyc < acc + 10) @(negedge clk_i);
        reset_ni        = 1'b0;
        bus.req_valid_i = 4'hF;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        @(negedge clk_i);
        bus.req_valid_i = '0;
        reset_ni = 1'b1;
        run_op(2, 8'd7, 8'd6, 16'h002A, "after_rst");

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
